// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use stall.
// Drives the ALU operands directly and counts stall cycles (saturating).
module ex_operand_stage #(
    parameter int N = 4,
    parameter int R = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic         flush_i,
    input  logic [2:0]   id_alu_sel_i,
    input  logic [R-1:0] id_rs1_i,
    input  logic [R-1:0] id_rs2_i,
    input  logic [R-1:0] id_rd_i,
    input  logic [N-1:0] id_rs1_data_i,
    input  logic [N-1:0] id_rs2_data_i,
    input  logic [N-1:0] id_imm_i,
    input  logic         id_use_imm_i,
    input  logic         id_reg_write_i,
    input  logic         id_mem_read_i,
    input  logic         id_mem_write_i,
    input  logic [R-1:0] mem_rd_i,
    input  logic         mem_reg_write_i,
    input  logic [N-1:0] mem_result_i,
    input  logic [R-1:0] wb_rd_i,
    input  logic         wb_reg_write_i,
    input  logic [N-1:0] wb_result_i,
    output logic [2:0]   alu_sel_o,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [N-1:0] ex_store_data_o,
    output logic [R-1:0] ex_rd_o,
    output logic         ex_reg_write_o,
    output logic         ex_mem_read_o,
    output logic         ex_mem_write_o,
    output logic         ex_valid_o,
    output logic         stall_o,
    output logic [7:0]   stall_cnt_o
);

    logic [2:0]   sel_q;
    logic [R-1:0] rs1_q, rs2_q, rd_q;
    logic [N-1:0] rs1_data_q, rs2_data_q, imm_q;
    logic         use_imm_q, reg_write_q, mem_read_q, mem_write_q, valid_q;
    logic [7:0]   stall_cnt_q;
    logic [N-1:0] fwd_a, fwd_b;
    logic         hit_rs1, hit_rs2;

    // rs2 only matters to the hazard when it is actually read (register operand or store data)
    always_comb begin
        hit_rs1 = (rd_q == id_rs1_i);
        hit_rs2 = (!id_use_imm_i || id_mem_write_i) && (rd_q == id_rs2_i);
        stall_o = valid_i && valid_q && mem_read_q && (rd_q != '0)
                  && (hit_rs1 || hit_rs2) && !flush_i;
    end

    always_comb begin
        fwd_a = rs1_data_q;
        if (rs1_q != '0) begin
            if (mem_reg_write_i && (mem_rd_i == rs1_q))     fwd_a = mem_result_i;
            else if (wb_reg_write_i && (wb_rd_i == rs1_q))  fwd_a = wb_result_i;
        end
        fwd_b = rs2_data_q;
        if (rs2_q != '0) begin
            if (mem_reg_write_i && (mem_rd_i == rs2_q))     fwd_b = mem_result_i;
            else if (wb_reg_write_i && (wb_rd_i == rs2_q))  fwd_b = wb_result_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || stall_o) begin
            sel_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            sel_q       <= id_alu_sel_i;
            rs1_q       <= id_rs1_i;
            rs2_q       <= id_rs2_i;
            rd_q        <= id_rd_i;
            rs1_data_q  <= id_rs1_data_i;
            rs2_data_q  <= id_rs2_data_i;
            imm_q       <= id_imm_i;
            use_imm_q   <= id_use_imm_i;
            reg_write_q <= id_reg_write_i && valid_i;
            mem_read_q  <= id_mem_read_i && valid_i;
            mem_write_q <= id_mem_write_i && valid_i;
            valid_q     <= valid_i;
        end
    end

    assign alu_sel_o       = sel_q;
    assign alu_a_o         = fwd_a;
    assign alu_b_o         = use_imm_q ? imm_q : fwd_b;
    assign ex_store_data_o = fwd_b;
    assign ex_rd_o         = rd_q;
    assign ex_reg_write_o  = reg_write_q;
    assign ex_mem_read_o   = mem_read_q;
    assign ex_mem_write_o  = mem_write_q;
    assign ex_valid_o      = valid_q;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: a reference model predicts each cycle's
// outputs, a monitor compares them on the falling edge.
module tb_ex_operand_stage;
    localparam int N = 4;
    localparam int R = 5;

    logic         clk_i = 1'b0;
    logic         rst_i, valid_i, flush_i;
    logic [2:0]   id_alu_sel_i;
    logic [R-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic [N-1:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic         id_use_imm_i, id_reg_write_i, id_mem_read_i, id_mem_write_i;
    logic [R-1:0] mem_rd_i, wb_rd_i;
    logic         mem_reg_write_i, wb_reg_write_i;
    logic [N-1:0] mem_result_i, wb_result_i;
    logic [2:0]   alu_sel_o;
    logic [N-1:0] alu_a_o, alu_b_o, ex_store_data_o;
    logic [R-1:0] ex_rd_o;
    logic         ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_valid_o, stall_o;
    logic [7:0]   stall_cnt_o;

    ex_operand_stage #(.N(N), .R(R)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
        .id_alu_sel_i(id_alu_sel_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_use_imm_i(id_use_imm_i), .id_reg_write_i(id_reg_write_i),
        .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
        .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i), .mem_result_i(mem_result_i),
        .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i), .wb_result_i(wb_result_i),
        .alu_sel_o(alu_sel_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o),
        .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_valid_o(ex_valid_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic rst, valid, flush;
        logic [2:0] sel;
        logic [R-1:0] rs1, rs2, rd;
        logic [N-1:0] d1, d2, imm;
        logic use_imm, rw, mr, mw;
        logic [R-1:0] mem_rd, wb_rd;
        logic mem_rw, wb_rw;
        logic [N-1:0] mem_res, wb_res;
    } stim_t;

    // instruction currently sitting in EX, as the model sees it
    typedef struct {
        logic valid;
        logic [2:0] sel;
        logic [R-1:0] rs1, rs2, rd;
        logic [N-1:0] d1, d2, imm;
        logic use_imm, rw, mr, mw;
    } ex_t;

    typedef struct {
        logic [2:0] sel;
        logic [N-1:0] a, b, st;
        logic [R-1:0] rd;
        logic rw, mr, mw, valid, stall;
        logic [7:0] cnt;
    } exp_t;

    int    total = 0;
    int    bad   = 0;
    exp_t  sb_q[$];
    ex_t   m;
    int    cnt_m;
    stim_t cur;
    logic  cur_stall;
    logic [2:0] ops [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] fwd_ref(input logic [R-1:0] a, input logic [N-1:0] d, input stim_t s);
        if (a == 0) return d;
        if (s.mem_rw && s.mem_rd == a) return s.mem_res;
        if (s.wb_rw && s.wb_rd == a) return s.wb_res;
        return d;
    endfunction

    function automatic stim_t nop_stim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst     = ($urandom_range(0, 99) == 0);
        s.valid   = ($urandom_range(0, 9) != 0);
        s.flush   = ($urandom_range(0, 9) == 0);
        s.sel     = ops[$urandom_range(0, 5)];
        s.rs1     = R'($urandom_range(0, 3));
        s.rs2     = R'($urandom_range(0, 3));
        s.rd      = R'($urandom_range(0, 3));
        s.d1      = (s.rs1 == 0) ? '0 : N'($urandom);
        s.d2      = (s.rs2 == 0) ? '0 : N'($urandom);
        s.imm     = N'($urandom);
        s.mr      = ($urandom_range(0, 2) == 0);
        s.mw      = !s.mr && ($urandom_range(0, 3) == 0);
        s.rw      = s.mr || ($urandom_range(0, 1) == 1);
        s.use_imm = s.mr || s.mw || ($urandom_range(0, 1) == 1);
        s.mem_rd  = R'($urandom_range(0, 3));
        s.wb_rd   = R'($urandom_range(0, 3));
        s.mem_rw  = ($urandom_range(0, 1) == 1);
        s.wb_rw   = ($urandom_range(0, 1) == 1);
        s.mem_res = N'($urandom);
        s.wb_res  = N'($urandom);
        return s;
    endfunction

    // apply one cycle's inputs and queue the outputs the model predicts for it
    task automatic drive(input stim_t s);
        exp_t e;
        logic dep;
        rst_i = s.rst; valid_i = s.valid; flush_i = s.flush;
        id_alu_sel_i = s.sel; id_rs1_i = s.rs1; id_rs2_i = s.rs2; id_rd_i = s.rd;
        id_rs1_data_i = s.d1; id_rs2_data_i = s.d2; id_imm_i = s.imm;
        id_use_imm_i = s.use_imm; id_reg_write_i = s.rw;
        id_mem_read_i = s.mr; id_mem_write_i = s.mw;
        mem_rd_i = s.mem_rd; mem_reg_write_i = s.mem_rw; mem_result_i = s.mem_res;
        wb_rd_i = s.wb_rd; wb_reg_write_i = s.wb_rw; wb_result_i = s.wb_res;
        // a load in EX feeding a register the ID instruction actually reads
        dep = (m.rd == s.rs1) || ((!s.use_imm || s.mw) && m.rd == s.rs2);
        cur_stall = s.valid && m.valid && m.mr && (m.rd != 0) && dep && !s.flush;
        e.sel   = m.sel;
        e.a     = fwd_ref(m.rs1, m.d1, s);
        e.st    = fwd_ref(m.rs2, m.d2, s);
        e.b     = m.use_imm ? m.imm : e.st;
        e.rd    = m.rd;
        e.rw    = m.rw;
        e.mr    = m.mr;
        e.mw    = m.mw;
        e.valid = m.valid;
        e.stall = cur_stall;
        e.cnt   = 8'(cnt_m);
        cur = s;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        if (cur.rst) begin
            m = '{default: '0};
            cnt_m = 0;
        end else begin
            if (cur_stall && cnt_m < 255) cnt_m++;
            if (cur.flush || cur_stall) begin
                m = '{default: '0};
            end else begin
                m.valid = cur.valid;
                m.sel = cur.sel; m.rs1 = cur.rs1; m.rs2 = cur.rs2; m.rd = cur.rd;
                m.d1 = cur.d1; m.d2 = cur.d2; m.imm = cur.imm; m.use_imm = cur.use_imm;
                m.rw = cur.rw && cur.valid;
                m.mr = cur.mr && cur.valid;
                m.mw = cur.mw && cur.valid;
            end
        end
        #1;
    endtask

    task automatic cycle(input stim_t s);
        drive(s);
        step();
    endtask

    function automatic stim_t load_stim();
        stim_t s;
        s = nop_stim();
        s.valid = 1; s.rd = 2; s.rs1 = 1; s.d1 = 4; s.imm = 3;
        s.use_imm = 1; s.mr = 1; s.rw = 1;
        return s;
    endfunction

    function automatic stim_t sub_stim();
        stim_t s;
        s = nop_stim();
        s.valid = 1; s.sel = 3'b001; s.rs1 = 2; s.rs2 = 3; s.d2 = 5; s.rd = 6; s.rw = 1;
        return s;
    endfunction

    always @(negedge clk_i) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("alu_sel",   32'(alu_sel_o),       32'(e.sel));
            chk("alu_a",     32'(alu_a_o),         32'(e.a));
            chk("alu_b",     32'(alu_b_o),         32'(e.b));
            chk("store",     32'(ex_store_data_o), 32'(e.st));
            chk("ex_rd",     32'(ex_rd_o),         32'(e.rd));
            chk("reg_write", 32'(ex_reg_write_o),  32'(e.rw));
            chk("mem_read",  32'(ex_mem_read_o),   32'(e.mr));
            chk("mem_write", 32'(ex_mem_write_o),  32'(e.mw));
            chk("ex_valid",  32'(ex_valid_o),      32'(e.valid));
            chk("stall",     32'(stall_o),         32'(e.stall));
            chk("stall_cnt", 32'(stall_cnt_o),     32'(e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        m = '{default: '0};
        cnt_m = 0;
        cur = nop_stim();
        cur_stall = 0;
        s = rand_stim();
        s.rst = 1;
        drive(s);
        void'(sb_q.pop_back());  // state before the first reset edge is unknown
        step();

        // reset with random inputs for two cycles
        repeat (2) begin
            s = rand_stim(); s.rst = 1; cycle(s);
        end
        s = rand_stim(); s.rst = 1; drive(s);
        @(negedge clk_i);
        chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rst_valid", 32'(ex_valid_o), 32'd0);
        step();

        // MEM forward, then MEM beats WB
        s = nop_stim(); s.valid = 1; s.rs1 = 3; s.rs2 = 4; s.d1 = 1; s.d2 = 2; s.rd = 5; s.rw = 1;
        cycle(s);
        s.mem_rd = 3; s.mem_rw = 1; s.mem_res = 9;
        drive(s);
        @(negedge clk_i);
        chk("memfwd_a", 32'(alu_a_o), 32'd9);
        chk("memfwd_b", 32'(alu_b_o), 32'd2);
        step();
        s.wb_rd = 3; s.wb_rw = 1; s.wb_res = 5;
        drive(s);
        @(negedge clk_i);
        chk("mem_over_wb", 32'(alu_a_o), 32'd9);
        step();

        // register 0 is never forwarded
        s = nop_stim(); s.valid = 1; s.rs1 = 0; s.rs2 = 1; s.d2 = 3; s.rd = 4;
        cycle(s);
        s.mem_rd = 0; s.mem_rw = 1; s.mem_res = 7; s.wb_rd = 0; s.wb_rw = 1; s.wb_res = 6;
        drive(s);
        @(negedge clk_i);
        chk("reg0_guard", 32'(alu_a_o), 32'd0);
        step();

        // load-use: one stall, a bubble, then SUB with rs1 from MEM
        s = nop_stim(); s.rst = 1; cycle(s);
        cycle(load_stim());
        drive(sub_stim());
        @(negedge clk_i);
        chk("lu_stall", 32'(stall_o), 32'd1);
        step();
        s = sub_stim(); s.mem_rd = 2; s.mem_rw = 1; s.mem_res = 4'hA;
        drive(s);
        @(negedge clk_i);
        chk("lu_bubble", 32'(ex_valid_o), 32'd0);
        chk("lu_stall_drop", 32'(stall_o), 32'd0);
        chk("lu_cnt", 32'(stall_cnt_o), 32'd1);
        step();
        s = nop_stim(); s.mem_rd = 2; s.mem_rw = 1; s.mem_res = 4'hA;
        drive(s);
        @(negedge clk_i);
        chk("lu_sub_valid", 32'(ex_valid_o), 32'd1);
        chk("lu_sub_a", 32'(alu_a_o), 32'hA);
        step();

        // flush wins over stall
        s = nop_stim(); s.rst = 1; cycle(s);
        cycle(load_stim());
        s = sub_stim(); s.flush = 1;
        drive(s);
        @(negedge clk_i);
        chk("flush_stall", 32'(stall_o), 32'd0);
        step();
        drive(nop_stim());
        @(negedge clk_i);
        chk("flush_bubble", 32'(ex_valid_o), 32'd0);
        chk("flush_cnt", 32'(stall_cnt_o), 32'd0);
        step();

        // reset arriving during a stall
        cycle(load_stim());
        s = sub_stim(); s.rst = 1; cycle(s);
        cycle(nop_stim());

        // counter saturation
        s = nop_stim(); s.rst = 1; cycle(s);
        for (int i = 0; i < 300; i++) begin
            cycle(load_stim());
            cycle(sub_stim());
        end
        drive(nop_stim());
        @(negedge clk_i);
        chk("sat_cnt", 32'(stall_cnt_o), 32'd255);
        step();
        cycle(load_stim());
        cycle(sub_stim());
        drive(nop_stim());
        @(negedge clk_i);
        chk("sat_hold", 32'(stall_cnt_o), 32'd255);
        step();

        // randomized traffic
        for (int i = 0; i < 2000; i++) cycle(rand_stim());
        drive(nop_stim());
        step();

        repeat (3) @(negedge clk_i);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
